// File: rtl/nios_system_dout_pkg.sv
// Register map and bit positions shared by the DOUT FIFO port.
package nios_system_dout_pkg;

  localparam logic [1:0] DOUT_ADDR_DATA    = 2'd0;
  localparam logic [1:0] DOUT_ADDR_STATUS  = 2'd1;
  localparam logic [1:0] DOUT_ADDR_CONTROL = 2'd2;
  localparam logic [1:0] DOUT_ADDR_LAST    = 2'd3;

  // STATUS[7:0] carries the fill count
  localparam int unsigned DOUT_STAT_COUNT_W = 8;
  localparam int unsigned DOUT_STAT_EMPTY   = 8;
  localparam int unsigned DOUT_STAT_FULL    = 9;
  localparam int unsigned DOUT_STAT_OVF     = 10;
  localparam int unsigned DOUT_STAT_IRQ_EN  = 11;

  localparam int unsigned DOUT_CTRL_FLUSH   = 0;
  localparam int unsigned DOUT_CTRL_CLR_OVF = 1;
  localparam int unsigned DOUT_CTRL_IRQ_EN  = 2;

endpackage

// File: rtl/nios_system_dout_fifo_core.sv
// Show-ahead FIFO storage: pointers, count, full/empty and push-while-full-and-popping.
module nios_system_dout_fifo_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // When full, a push is only taken if the head slot is freed in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_dout_fifo.sv
// Avalon-MM byte output port: register decode, OVERFLOW, LAST, readdata and optional irq.
// Optional feature macro: DOUT_IRQ_EN adds the registered irq output.
module nios_system_dout_fifo
  import nios_system_dout_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef DOUT_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr;
  logic          data_wr;
  logic          ctrl_wr;
  logic          flush;
  logic          pop;
  logic          ovf_set;
  logic          overflow;
  logic          irq_en;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [DATA_WIDTH-1:0] last;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  assign wr      = chipselect && !write_n;
  assign data_wr = wr && (address == DOUT_ADDR_DATA);
  assign ctrl_wr = wr && (address == DOUT_ADDR_CONTROL);
  assign flush   = ctrl_wr && writedata[DOUT_CTRL_FLUSH];

  // A flush swallows a coincident pop, so LAST keeps its old value too
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !flush;
  assign ovf_set   = data_wr && full && !pop;
  assign unused_wdata = ^writedata;

  nios_system_dout_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .push      (data_wr),
    .push_data (writedata[DATA_WIDTH-1:0]),
    .pop       (pop),
    .flush     (flush),
    .head      (out_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      last     <= '0;
    end else begin
      if (ovf_set)
        overflow <= 1'b1;
      else if (ctrl_wr && writedata[DOUT_CTRL_CLR_OVF])
        overflow <= 1'b0;
      if (ctrl_wr) irq_en <= writedata[DOUT_CTRL_IRQ_EN];
      if (pop) last <= out_data;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      DOUT_ADDR_STATUS: begin
        rd_mux[DOUT_STAT_COUNT_W-1:0] = DOUT_STAT_COUNT_W'(count);
        rd_mux[DOUT_STAT_EMPTY]       = empty;
        rd_mux[DOUT_STAT_FULL]        = full;
        rd_mux[DOUT_STAT_OVF]         = overflow;
        rd_mux[DOUT_STAT_IRQ_EN]      = irq_en;
      end
      DOUT_ADDR_CONTROL: rd_mux[DOUT_CTRL_IRQ_EN] = irq_en;
      DOUT_ADDR_LAST:    rd_mux[DATA_WIDTH-1:0]   = last;
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

`ifdef DOUT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_en && (empty || overflow);
  end
`endif

endmodule
